// File: rtl/reg_store_unit.sv
// Store path from the register bank to RAM: lane formatting, single-outstanding write, ack timeout.
// Optional macro STORE_MISALIGN_TRAP_EN: misaligned half/word stores abort with err instead of being force-aligned.
//
// state   | meaning
// IDLE    | ready for a new STR request
// WRITE   | ramWe asserted, waiting for ramAck or timeout
// DONE    | one-cycle completion pulse
// ERROR   | one-cycle abort pulse (illegal request or timeout)
module reg_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              strEn,
    output logic              strReady,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       regData,
    input  logic [1:0]        size,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [31:0]       ramWdata,
    output logic [3:0]        ramBe,
    output logic              ramWe,
    input  logic              ramAck,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;

    logic              w_legal;
    logic [31:0]       w_wdata;
    logic [3:0]        w_be;
    logic              w_accept;

    always_comb begin
        w_legal = (size != 2'b11);
`ifdef STORE_MISALIGN_TRAP_EN
        if (size == 2'b01 && addr[0])
            w_legal = 1'b0;
        if (size == 2'b10 && addr[1:0] != 2'b00)
            w_legal = 1'b0;
`endif
    end

    // Half-word lane select ignores addr[0], which is what force-aligns a misaligned half.
    always_comb begin
        w_wdata = regData;
        w_be    = 4'b1111;
        case (size)
            2'b00: begin
                w_wdata = {4{regData[7:0]}};
                w_be    = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{regData[15:0]}};
                w_be    = 4'b0011 << {addr[1], 1'b0};
            end
            default: begin
                w_wdata = regData;
                w_be    = 4'b1111;
            end
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && strEn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                        r_cnt   <= '0;
                        r_state <= w_legal ? S_WRITE : S_ERROR;
                    end
                end
                S_WRITE: begin
                    // An ack in the final allowed cycle still counts as success.
                    if (ramAck) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == C_LAST)
                            r_state <= S_ERROR;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERROR: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign strReady = (r_state == S_IDLE);
    assign busy     = !strReady;
    assign ramWe    = (r_state == S_WRITE);
    assign ramBe    = ramWe ? r_be : 4'b0000;
    assign ramAddr  = r_addr;
    assign ramWdata = r_wdata;
    assign done     = (r_state == S_DONE);
    assign err      = (r_state == S_ERROR);

endmodule

// File: tb/tb_reg_store_unit.sv
// Scoreboard bench for reg_store_unit: driver queues expected writes/outcomes, negedge monitor checks them.
module tb_reg_store_unit;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    localparam int K_WR  = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              strEn = 1'b0;
    logic              strReady;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       regData = '0;
    logic [1:0]        size = '0;
    logic [ADDR_W-1:0] ramAddr;
    logic [31:0]       ramWdata;
    logic [3:0]        ramBe;
    logic              ramWe;
    logic              ramAck = 1'b0;
    logic              done;
    logic              err;
    logic              busy;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        int          n;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   we_run   = 0;
    logic prev_we  = 1'b0;

    reg_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .strEn(strEn), .strReady(strReady),
        .addr(addr), .regData(regData), .size(size),
        .ramAddr(ramAddr), .ramWdata(ramWdata), .ramBe(ramBe), .ramWe(ramWe),
        .ramAck(ramAck), .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        e.kind = K_WR; e.a = a; e.d = d; e.be = be; e.n = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_end(input int kind, input int n);
        exp_t e;
        e.kind = kind; e.a = '0; e.d = '0; e.be = '0; e.n = n;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the oldest expectation whenever the DUT starts a write or pulses done/err.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            we_run  = 0;
            prev_we = 1'b0;
        end else begin
            chk("done_err_exclusive", 32'(done & err), 32'd0);
            if (ramWe && !prev_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_kind", 32'(e.kind), 32'(K_WR));
                    chk("ramAddr", ramAddr, e.a);
                    chk("ramWdata", ramWdata, e.d);
                    chk("ramBe", 32'(ramBe), 32'(e.be));
                end
            end
            if (ramWe)
                we_run++;
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("outcome_kind", 32'(done ? K_DONE : K_ERR), 32'(e.kind));
                    chk("we_cycles", 32'(we_run), 32'(e.n));
                end
                we_run = 0;
            end
            prev_we = ramWe;
        end
    end

    task automatic wait_ready();
        int i;
        for (i = 0; i < 50 && !strReady; i++)
            @(posedge clk) #1;
        if (!strReady)
            chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // One request. ack_at = WRITE cycle (1-based) in which ramAck is raised; 0 = never.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input bit wr, input int ack_at);
        wait_ready();
        addr = a; regData = d; size = sz; strEn = 1'b1;
        @(posedge clk) #1;
        strEn = 1'b0;
        if (wr) begin
            for (int c = 1; c <= TIMEOUT + 2; c++) begin
                ramAck = (c == ack_at);
                @(posedge clk) #1;
                ramAck = 1'b0;
                if (!ramWe)
                    break;
            end
            chk("ramWe_dropped", 32'(ramWe), 32'd0);
            if (ack_at != 0) begin
                chk("ready_in_done", 32'(strReady), 32'd0);
                @(posedge clk) #1;
                chk("ready_after_ack", 32'(strReady), 32'd1);
            end else begin
                @(posedge clk) #1;
            end
        end else begin
            chk("no_write_illegal", 32'(ramWe), 32'd0);
            @(posedge clk) #1;
        end
    endtask

    initial begin
        #12;
        chk("rst_ramWe", 32'(ramWe), 32'd0);
        chk("rst_ramBe", 32'(ramBe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk) #1;
        chk("rst_strReady", 32'(strReady), 32'd1);
        chk("rst_ramAddr", ramAddr, 32'd0);
        chk("rst_ramWdata", ramWdata, 32'd0);

        push_wr(32'h100, 32'hDDDDDDDD, 4'b1000); push_end(K_DONE, 2);
        store(32'h103, 32'hAABBCCDD, 2'b00, 1'b1, 2);

        push_wr(32'h20, 32'hBEEFBEEF, 4'b1100); push_end(K_DONE, 1);
        store(32'h22, 32'h1234BEEF, 2'b01, 1'b1, 1);

        push_wr(32'h40, 32'h11223344, 4'b1111); push_end(K_ERR, 15);
        store(32'h40, 32'h11223344, 2'b10, 1'b1, 0);

        push_wr(32'h40, 32'hCAFEF00D, 4'b1111); push_end(K_DONE, 15);
        store(32'h40, 32'hCAFEF00D, 2'b10, 1'b1, 15);

        push_wr(32'h0, 32'hEEEEEEEE, 4'b0010); push_end(K_DONE, 4);
        store(32'h01, 32'h000000EE, 2'b00, 1'b1, 4);

        push_end(K_ERR, 0);
        store(32'h10, 32'h01020304, 2'b11, 1'b0, 0);

`ifdef STORE_MISALIGN_TRAP_EN
        push_end(K_ERR, 0);
        store(32'h06, 32'h55667788, 2'b10, 1'b0, 0);
        push_end(K_ERR, 0);
        store(32'h33, 32'h0000A5A5, 2'b01, 1'b0, 0);
`else
        push_wr(32'h04, 32'h55667788, 4'b1111); push_end(K_DONE, 3);
        store(32'h06, 32'h55667788, 2'b10, 1'b1, 3);
        push_wr(32'h30, 32'hA5A5A5A5, 4'b1100); push_end(K_DONE, 1);
        store(32'h33, 32'h0000A5A5, 2'b01, 1'b1, 1);
`endif

        // Back-to-back with strEn held high; the second request must wait for IDLE.
        wait_ready();
        push_wr(32'h200, 32'h11111111, 4'b0001); push_end(K_DONE, 1);
        push_wr(32'h300, 32'hDEADBEEF, 4'b1111); push_end(K_DONE, 1);
        addr = 32'h200; regData = 32'h00000011; size = 2'b00; strEn = 1'b1;
        @(posedge clk) #1;
        addr = 32'h300; regData = 32'hDEADBEEF; size = 2'b10;
        ramAck = 1'b1;
        @(posedge clk) #1;
        ramAck = 1'b0;
        chk("b2b_ready_done", 32'(strReady), 32'd0);
        chk("b2b_we_done", 32'(ramWe), 32'd0);
        @(posedge clk) #1;
        chk("b2b_ready_idle", 32'(strReady), 32'd1);
        chk("b2b_we_idle", 32'(ramWe), 32'd0);
        @(posedge clk) #1;
        strEn = 1'b0;
        chk("b2b_second_we", 32'(ramWe), 32'd1);
        ramAck = 1'b1;
        @(posedge clk) #1;
        ramAck = 1'b0;
        @(posedge clk) #1;

        // Stray ack while idle.
        ramAck = 1'b1;
        repeat (3) begin
            @(posedge clk) #1;
            chk("stray_ack_done", 32'(done), 32'd0);
            chk("stray_ack_busy", 32'(busy), 32'd0);
        end
        ramAck = 1'b0;

        // Reset in the middle of a write.
        wait_ready();
        push_wr(32'h80, 32'h0BADF00D, 4'b1111);
        addr = 32'h80; regData = 32'h0BADF00D; size = 2'b10; strEn = 1'b1;
        @(posedge clk) #1;
        strEn = 1'b0;
        repeat (3) @(posedge clk) #1;
        chk("pre_rst_we", 32'(ramWe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ramWe", 32'(ramWe), 32'd0);
        chk("midrst_ramBe", 32'(ramBe), 32'd0);
        chk("midrst_ramAddr", ramAddr, 32'd0);
        chk("midrst_ramWdata", ramWdata, 32'd0);
        chk("midrst_done_err", 32'({done, err}), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk) #1;
        chk("inrst_done_err", 32'({done, err}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk) #1;
        chk("postrst_strReady", 32'(strReady), 32'd1);
        repeat (3) @(posedge clk) #1;
        chk("postrst_no_pulse", 32'({done, err, ramWe}), 32'd0);

        repeat (3) @(posedge clk) #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
